// File: rtl/rf_scoreboard_arbiter.sv
// rtl/rf_scoreboard_arbiter.sv - register-file write scoreboard and writeback arbiter
//
// Tracks in-flight writes per architectural register so decode can be held on
// RAW hazards, and arbitrates the single register-file write port between the
// ALU and load writeback streams.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   id_valid/id_src*/id_dest*        decode-side instruction operands
//   id_stall                         combinational hold request to decode
//   alu_wb_* / mem_wb_*              writeback request streams (valid/ready)
//   rf_write_enable/rf_dest/rf_dest_val  registered register-file write port
//   sb_error                         sticky: a write retired against a zero counter
module rf_scoreboard_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 2,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic              id_src1_used,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_src2_used,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_dest_used,
  output logic              id_stall,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_dest,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic [ADDR_W-1:0] mem_wb_dest,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_dest,
  output logic [DATA_W-1:0] rf_dest_val,
  output logic              sb_error
);

  localparam int ST_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d [NUM_REGS];
  logic [ST_W-1:0]   starve_q, starve_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_dest_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              err_q, err_set;

  logic              hazard, issue;
  logic              alu_gnt, mem_gnt, any_gnt;
  logic [ADDR_W-1:0] gnt_dest;
  logic [DATA_W-1:0] gnt_data;
  logic [NUM_REGS-1:0] inc_vec, dec_vec;

  // cnt_q[0] is pinned at zero (never incremented), so source 0 cannot hazard.
  always_comb begin
    hazard = (id_src1_used && (cnt_q[id_src1] != '0)) ||
             (id_src2_used && (cnt_q[id_src2] != '0)) ||
             (id_dest_used && (id_dest != '0) && (cnt_q[id_dest] == CNT_MAX));
    id_stall = id_valid && hazard;
    issue    = id_valid && !hazard;
  end

  // Mem wins by default; the ALU takes the port once it has lost STARVE_LIM
  // consecutive cycles.
  always_comb begin
    alu_gnt  = alu_wb_valid && ((starve_q == ST_W'(STARVE_LIM)) || !mem_wb_valid);
    mem_gnt  = mem_wb_valid && !alu_gnt;
    any_gnt  = alu_gnt || mem_gnt;
    gnt_dest = alu_gnt ? alu_wb_dest : mem_wb_dest;
    gnt_data = alu_gnt ? alu_wb_data : mem_wb_data;
    starve_d = (alu_wb_valid && !alu_gnt) ? starve_q + 1'b1 : '0;
    alu_wb_ready = alu_gnt;
    mem_wb_ready = mem_gnt;
  end

  // Register 0 never sets a bit here, so the per-register update below can
  // treat every index uniformly.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue && id_dest_used && (id_dest != '0)) inc_vec[id_dest] = 1'b1;
    if (any_gnt && (gnt_dest != '0))              dec_vec[gnt_dest] = 1'b1;
  end

  always_comb begin
    err_set = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] == '0) err_set = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
      starve_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_dest_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      wr_en_q  <= any_gnt;
      if (any_gnt) begin
        wr_dest_q <= gnt_dest;
        wr_data_q <= gnt_data;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  assign rf_write_enable = wr_en_q;
  assign rf_dest         = wr_dest_q;
  assign rf_dest_val     = wr_data_q;
  assign sb_error        = err_q;

endmodule

// File: tb/tb_rf_scoreboard_arbiter.sv
// tb/tb_rf_scoreboard_arbiter.sv - self-checking bench for rf_scoreboard_arbiter
module tb_rf_scoreboard_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid, id_src1_used, id_src2_used, id_dest_used;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic        id_stall;
  logic        alu_wb_valid, alu_wb_ready, mem_wb_valid, mem_wb_ready;
  logic [4:0]  alu_wb_dest, mem_wb_dest;
  logic [31:0] alu_wb_data, mem_wb_data;
  logic        rf_write_enable, sb_error;
  logic [4:0]  rf_dest;
  logic [31:0] rf_dest_val;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0]  d;
    logic [31:0] v;
  } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  rf_scoreboard_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used),
    .id_dest(id_dest), .id_dest_used(id_dest_used), .id_stall(id_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_dest(alu_wb_dest), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_dest(mem_wb_dest), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_write_enable(rf_write_enable), .rf_dest(rf_dest), .rf_dest_val(rf_dest_val),
    .sb_error(sb_error)
  );

  // Scoreboard monitor: every observed register-file write pops the oldest
  // expected write.
  always @(negedge clk) begin
    if (reset_n && rf_write_enable) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rf_unexpected_write got dest=%0d data=%h required no write", rf_dest, rf_dest_val);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_dest !== e.d || rf_dest_val !== e.v) begin
          miscompares++;
          $display("FAIL rf_write got dest=%0d data=%h required dest=%0d data=%h",
                   rf_dest, rf_dest_val, e.d, e.v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_src1 = 0; id_src1_used = 0; id_src2 = 0; id_src2_used = 0;
    id_dest = 0; id_dest_used = 0;
    alu_wb_valid = 0; alu_wb_dest = 0; alu_wb_data = 0;
    mem_wb_valid = 0; mem_wb_dest = 0; mem_wb_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic s1u,
                        input logic [4:0] d, input logic du);
    id_valid = v; id_src1 = s1; id_src1_used = s1u; id_src2 = 0; id_src2_used = 0;
    id_dest = d; id_dest_used = du;
  endtask

  task automatic test_drain();
    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending writes required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    #12;
    vectors++;
    if (rf_write_enable !== 0 || rf_dest !== 0 || rf_dest_val !== 0 || sb_error !== 0) begin
      miscompares++;
      $display("FAIL reset_outputs got we=%b dest=%0d val=%h err=%b required 0", rf_write_enable, rf_dest, rf_dest_val, sb_error);
    end
    reset_n = 1;
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0);
    mem_wb_valid = 1;
    #1;
    vectors++;
    if (id_stall !== 0) begin miscompares++; $display("FAIL reset_stall got %b required 0", id_stall); end
    vectors++;
    if (mem_wb_ready !== 1 || alu_wb_ready !== 0) begin
      miscompares++;
      $display("FAIL reset_ready got mem=%b alu=%b required mem=1 alu=0", mem_wb_ready, alu_wb_ready);
    end
    idle_inputs();
  endtask

  task automatic test_raw_hazard();
    tick();
    set_id(1, 5'd0, 0, 5'd5, 1);
    #1;
    vectors++;
    if (id_stall !== 0) begin miscompares++; $display("FAIL raw_issue got stall=%b required 0", id_stall); end
    tick();
    set_id(1, 5'd5, 1, 5'd0, 0);
    mem_wb_valid = 1; mem_wb_dest = 5; mem_wb_data = 32'hDEADBEEF;
    #1;
    vectors++;
    if (id_stall !== 1) begin miscompares++; $display("FAIL raw_stall got %b required 1", id_stall); end
    vectors++;
    if (mem_wb_ready !== 1 || alu_wb_ready !== 0) begin
      miscompares++;
      $display("FAIL raw_grant got mem=%b alu=%b required mem=1 alu=0", mem_wb_ready, alu_wb_ready);
    end
    exp_q.push_back('{d: 5'd5, v: 32'hDEADBEEF});
    tick();
    mem_wb_valid = 0;
    #1;
    vectors++;
    if (rf_write_enable !== 1 || rf_dest !== 5 || rf_dest_val !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL raw_write got we=%b dest=%0d val=%h required 1/5/deadbeef", rf_write_enable, rf_dest, rf_dest_val);
    end
    vectors++;
    if (id_stall !== 0) begin miscompares++; $display("FAIL raw_release got stall=%b required 0", id_stall); end
    tick();
    idle_inputs();
    test_drain();
  endtask

  task automatic test_starvation();
    tick();
    alu_wb_valid = 1; alu_wb_dest = 0; alu_wb_data = 32'hA1A10000;
    for (int k = 0; k < 4; k++) begin
      mem_wb_valid = 1; mem_wb_dest = 0; mem_wb_data = 32'h4D000000 + k;
      #1;
      vectors++;
      if (alu_wb_ready !== (k == 3) || mem_wb_ready !== (k != 3)) begin
        miscompares++;
        $display("FAIL starve_cycle%0d got alu=%b mem=%b required alu=%b mem=%b",
                 k, alu_wb_ready, mem_wb_ready, (k == 3), (k != 3));
      end
      if (k == 3) exp_q.push_back('{d: 5'd0, v: 32'hA1A10000});
      else        exp_q.push_back('{d: 5'd0, v: 32'h4D000000 + k});
      tick();
    end
    idle_inputs();
    test_drain();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      tick();
      set_id(1, 5'd0, 0, 5'd7, 1);
      #1;
      vectors++;
      if (id_stall !== 0) begin miscompares++; $display("FAIL sat_issue%0d got stall=%b required 0", k, id_stall); end
    end
    tick();
    #1;
    vectors++;
    if (id_stall !== 1) begin miscompares++; $display("FAIL sat_full got stall=%b required 1", id_stall); end
    alu_wb_valid = 1; alu_wb_dest = 7; alu_wb_data = 32'h00000777;
    #1;
    exp_q.push_back('{d: 5'd7, v: 32'h00000777});
    tick();
    alu_wb_valid = 0;
    #1;
    vectors++;
    if (id_stall !== 0) begin miscompares++; $display("FAIL sat_release got stall=%b required 0", id_stall); end
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      mem_wb_valid = 1; mem_wb_dest = 7; mem_wb_data = 32'h70 + k;
      exp_q.push_back('{d: 5'd7, v: 32'h70 + k});
      tick();
    end
    idle_inputs();
    test_drain();
    vectors++;
    if (sb_error !== 0) begin miscompares++; $display("FAIL sat_err got %b required 0", sb_error); end
  endtask

  task automatic test_same_edge();
    tick();
    set_id(1, 5'd0, 0, 5'd9, 1);
    tick();
    set_id(1, 5'd0, 0, 5'd9, 1);
    mem_wb_valid = 1; mem_wb_dest = 9; mem_wb_data = 32'h99;
    #1;
    vectors++;
    if (id_stall !== 0 || mem_wb_ready !== 1) begin
      miscompares++;
      $display("FAIL same_edge_issue got stall=%b ready=%b required 0/1", id_stall, mem_wb_ready);
    end
    exp_q.push_back('{d: 5'd9, v: 32'h99});
    tick();
    idle_inputs();
    set_id(1, 5'd9, 1, 5'd0, 0);
    #1;
    vectors++;
    if (id_stall !== 1) begin miscompares++; $display("FAIL same_edge_count got stall=%b required 1", id_stall); end
    vectors++;
    if (sb_error !== 0) begin miscompares++; $display("FAIL same_edge_err got %b required 0", sb_error); end
    mem_wb_valid = 1; mem_wb_dest = 9; mem_wb_data = 32'h9A;
    exp_q.push_back('{d: 5'd9, v: 32'h9A});
    tick();
    mem_wb_valid = 0;
    #1;
    vectors++;
    if (id_stall !== 0) begin miscompares++; $display("FAIL same_edge_drain got stall=%b required 0", id_stall); end
    idle_inputs();
    test_drain();
  endtask

  task automatic test_zero_error();
    tick();
    alu_wb_valid = 1; alu_wb_dest = 12; alu_wb_data = 32'h12121212;
    #1;
    vectors++;
    if (alu_wb_ready !== 1) begin miscompares++; $display("FAIL err_grant got %b required 1", alu_wb_ready); end
    exp_q.push_back('{d: 5'd12, v: 32'h12121212});
    tick();
    alu_wb_valid = 0;
    vectors++;
    if (sb_error !== 1) begin miscompares++; $display("FAIL err_set got %b required 1", sb_error); end
    for (int k = 0; k < 4; k++) begin
      id_valid = 1; id_src1 = 0; id_src1_used = 1; id_src2 = 0; id_src2_used = 1;
      id_dest = 0; id_dest_used = 1;
      #1;
      vectors++;
      if (id_stall !== 0) begin miscompares++; $display("FAIL zero_reg%0d got stall=%b required 0", k, id_stall); end
      tick();
    end
    set_id(1, 5'd12, 1, 5'd0, 0);
    #1;
    vectors++;
    if (id_stall !== 0) begin miscompares++; $display("FAIL err_cnt12 got stall=%b required 0", id_stall); end
    vectors++;
    if (sb_error !== 1) begin miscompares++; $display("FAIL err_sticky got %b required 1", sb_error); end
    idle_inputs();
    test_drain();
  endtask

  task automatic test_reset_mid();
    tick();
    set_id(1, 5'd0, 0, 5'd3, 1);
    tick();
    tick();
    set_id(1, 5'd3, 1, 5'd0, 0);
    #1;
    vectors++;
    if (id_stall !== 1) begin miscompares++; $display("FAIL mid_pre got stall=%b required 1", id_stall); end
    #2;
    reset_n = 0;
    #1;
    vectors++;
    if (id_stall !== 0 || rf_write_enable !== 0 || sb_error !== 0) begin
      miscompares++;
      $display("FAIL mid_reset got stall=%b we=%b err=%b required 0/0/0", id_stall, rf_write_enable, sb_error);
    end
    tick();
    reset_n = 1;
    tick();
    #1;
    vectors++;
    if (id_stall !== 0) begin miscompares++; $display("FAIL mid_after got stall=%b required 0", id_stall); end
    idle_inputs();
    test_drain();
  endtask

  initial begin
    test_reset();
    test_raw_hazard();
    test_starvation();
    test_saturation();
    test_same_edge();
    test_zero_error();
    test_reset_mid();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
